// File: rtl/rootsqr_credit_fifo.sv
// Credit-based admission wrapper for the fixed-latency rootsqr pipeline.
// Launches only with guaranteed buffer space; results drain through a FWFT FIFO.
`timescale 1ns/1ps
module rootsqr_credit_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LAT   = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       issue,
  input  logic                       res_valid,
  input  logic [WIDTH-1:0]           res_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       err_ovf,
  output logic                       err_spur
);

  localparam int unsigned   CW      = $clog2(DEPTH + 1);
  localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  if (LAT < 1) begin : g_lat_chk
    $error("rootsqr_credit_fifo: LAT must be at least 1");
  end

  logic [CW-1:0]    credits_q, credits_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    level_q, level_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic             in_ready_q, m_valid_q;
  logic             err_ovf_q, err_ovf_d;
  logic             err_spur_q, err_spur_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic pop_s, issue_s, full_s, push_s, drop_s, ret_s, spur_s;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    if (p == LAST_C) begin
      return '0;
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign pop_s   = m_valid_q & m_ready;
  assign issue_s = in_valid & in_ready_q;
  assign full_s  = (level_q == DEPTH_C);
  // A full FIFO still accepts a result when its head leaves in the same cycle.
  assign push_s  = res_valid & (~full_s | pop_s);
  assign drop_s  = res_valid & full_s & ~pop_s;
  assign ret_s   = res_valid & (inflight_q != '0);
  assign spur_s  = res_valid & (inflight_q == '0);

  always_comb begin
    credits_d  = credits_q;
    inflight_d = inflight_q;
    level_d    = level_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    err_ovf_d  = err_ovf_q | drop_s;
    err_spur_d = err_spur_q | spur_s;

    // Saturation only matters after an error has broken the credit accounting.
    if (issue_s && !pop_s) begin
      credits_d = credits_q - CW'(1);
    end else if (pop_s && !issue_s && (credits_q != DEPTH_C)) begin
      credits_d = credits_q + CW'(1);
    end else begin
      credits_d = credits_q;
    end

    if (issue_s && !ret_s && (inflight_q != '1)) begin
      inflight_d = inflight_q + CW'(1);
    end else if (ret_s && !issue_s) begin
      inflight_d = inflight_q - CW'(1);
    end else begin
      inflight_d = inflight_q;
    end

    if (push_s && !pop_s) begin
      level_d = level_q + CW'(1);
    end else if (pop_s && !push_s) begin
      level_d = level_q - CW'(1);
    end else begin
      level_d = level_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s) begin
      wr_ptr_d = ptr_next(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q  <= DEPTH_C;
      inflight_q <= '0;
      level_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      in_ready_q <= 1'b1;
      m_valid_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_spur_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      inflight_q <= inflight_d;
      level_q    <= level_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      in_ready_q <= (credits_d != '0);
      m_valid_q  <= (level_d != '0);
      err_ovf_q  <= err_ovf_d;
      err_spur_q <= err_spur_d;
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= res_data;
    end
  end

  assign in_ready = in_ready_q;
  assign issue    = issue_s;
  assign m_valid  = m_valid_q;
  assign m_data   = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign err_ovf  = err_ovf_q;
  assign err_spur = err_spur_q;

endmodule
